// File: rtl/px_cmd_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : px_cmd_if
// Purpose  : Bundles the front-panel inputs, the pixel-write handshake to the
//            display driver and the cursor/status outputs of px_cmd_ctrl.
// Signals  : buttons[3:1]  synchronised buttons (step / plot / clear)
//            switches[1:0] synchronised colour select
//            px_ready      ack from display driver
//            px_valid      pixel write request
//            px_x, px_y    write coordinate
//            px_colour     write colour
//            cur_x, cur_y  current cursor
//            busy          sequencer not idle
// Modports : master = command controller, slave = panel/driver side
// Revision : 1.0 - initial release
// ============================================================================
interface px_cmd_if #(
  parameter int XW = 4,
  parameter int YW = 4
);
  logic [3:1]    buttons;
  logic [1:0]    switches;
  logic          px_ready;
  logic          px_valid;
  logic [XW-1:0] px_x;
  logic [YW-1:0] px_y;
  logic [1:0]    px_colour;
  logic [XW-1:0] cur_x;
  logic [YW-1:0] cur_y;
  logic          busy;

  modport master (
    input  buttons, switches, px_ready,
    output px_valid, px_x, px_y, px_colour, cur_x, cur_y, busy
  );

  modport slave (
    output buttons, switches, px_ready,
    input  px_valid, px_x, px_y, px_colour, cur_x, cur_y, busy
  );
endinterface
`default_nettype wire

// File: rtl/px_cmd_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : px_cmd_ctrl
// Purpose  : Front-panel command sequencer. Debounces the three buttons,
//            turns presses into step-cursor / plot / clear-screen commands and
//            issues pixel writes to the display driver over a four-phase
//            valid/ready handshake. Owns the cursor position.
// Ports    : clk    system clock
//            rst_a  asynchronous active-high reset
//            bus    px_cmd_if.master (buttons, switches, px_ready in;
//                   px_valid, px_x, px_y, px_colour, cur_x, cur_y, busy out)
// Revision : 1.0 - initial release
// ============================================================================
module px_cmd_ctrl #(
  parameter int XW              = 4,
  parameter int YW              = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  wire logic clk,
  input  wire logic rst_a,
  px_cmd_if.master  bus
);

  localparam int                 c_CNT_W   = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_REQ         = 3'd1,
    ST_RELEASE     = 3'd2,
    ST_CLR_REQ     = 3'd3,
    ST_CLR_RELEASE = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Debounce: one counter per button. The press pulse is registered on the
  // same edge that the stable value rises, so it is seen the cycle after the
  // stable value was decided.
  // --------------------------------------------------------------------------
  logic [3:1] w_press;

  for (genvar gi = 1; gi <= 3; gi++) begin : g_debounce
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_stable;
    logic               r_press;

    always_ff @(posedge clk or posedge rst_a) begin
      if (rst_a) begin
        r_cnt    <= '0;
        r_stable <= 1'b0;
        r_press  <= 1'b0;
      end else begin
        r_press <= 1'b0;
        if (bus.buttons[gi] == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == c_CNT_MAX) begin
          r_stable <= bus.buttons[gi];
          r_cnt    <= '0;
          r_press  <= bus.buttons[gi];
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    assign w_press[gi] = r_press;
  end

  // --------------------------------------------------------------------------
  // Sequencer
  // --------------------------------------------------------------------------
  state_t          r_state,     w_state_nxt;
  logic [XW-1:0]   r_cur_x,     w_cur_x_nxt;
  logic [YW-1:0]   r_cur_y,     w_cur_y_nxt;
  logic [XW-1:0]   r_px_x,      w_px_x_nxt;
  logic [YW-1:0]   r_px_y,      w_px_y_nxt;
  logic [1:0]      r_px_colour, w_px_colour_nxt;
  logic            r_px_valid,  w_px_valid_nxt;
  logic [XW+YW-1:0] w_clr_pos;

  // Raster successor of the pixel just cleared: X is the low part, so a
  // single increment walks X fastest and carries into Y.
  assign w_clr_pos = {r_px_y, r_px_x} + 1'b1;

  always_ff @(posedge clk or posedge rst_a) begin
    if (rst_a) begin
      r_state     <= ST_IDLE;
      r_cur_x     <= '0;
      r_cur_y     <= '0;
      r_px_x      <= '0;
      r_px_y      <= '0;
      r_px_colour <= '0;
      r_px_valid  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_x     <= w_cur_x_nxt;
      r_cur_y     <= w_cur_y_nxt;
      r_px_x      <= w_px_x_nxt;
      r_px_y      <= w_px_y_nxt;
      r_px_colour <= w_px_colour_nxt;
      r_px_valid  <= w_px_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cur_x_nxt     = r_cur_x;
    w_cur_y_nxt     = r_cur_y;
    w_px_x_nxt      = r_px_x;
    w_px_y_nxt      = r_px_y;
    w_px_colour_nxt = r_px_colour;
    w_px_valid_nxt  = r_px_valid;

    case (r_state)
      ST_IDLE: begin
        // A high px_ready here is a stale ack; commands are not started until
        // the driver has returned to idle, and pulses are not queued.
        if (!bus.px_ready) begin
          if (w_press[3]) begin
            w_px_x_nxt      = '0;
            w_px_y_nxt      = '0;
            w_px_colour_nxt = 2'b00;
            w_px_valid_nxt  = 1'b1;
            w_state_nxt     = ST_CLR_REQ;
          end else if (w_press[2]) begin
            w_px_x_nxt      = r_cur_x;
            w_px_y_nxt      = r_cur_y;
            w_px_colour_nxt = bus.switches;
            w_px_valid_nxt  = 1'b1;
            w_state_nxt     = ST_REQ;
          end else if (w_press[1]) begin
            if (r_cur_x == {XW{1'b1}}) begin
              w_cur_x_nxt = '0;
              w_cur_y_nxt = r_cur_y + 1'b1;
            end else begin
              w_cur_x_nxt = r_cur_x + 1'b1;
            end
          end
        end
      end

      ST_REQ: begin
        if (bus.px_ready) begin
          w_px_valid_nxt = 1'b0;
          w_state_nxt    = ST_RELEASE;
        end
      end

      ST_RELEASE: begin
        if (!bus.px_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_CLR_REQ: begin
        if (bus.px_ready) begin
          w_px_valid_nxt = 1'b0;
          w_state_nxt    = ST_CLR_RELEASE;
        end
      end

      ST_CLR_RELEASE: begin
        if (!bus.px_ready) begin
          if ((r_px_x == {XW{1'b1}}) && (r_px_y == {YW{1'b1}})) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_px_x_nxt     = w_clr_pos[XW-1:0];
            w_px_y_nxt     = w_clr_pos[XW+YW-1:XW];
            w_px_valid_nxt = 1'b1;
            w_state_nxt    = ST_CLR_REQ;
          end
        end
      end

      default: begin
        w_px_valid_nxt = 1'b0;
        w_state_nxt    = ST_IDLE;
      end
    endcase
  end

  assign bus.px_valid  = r_px_valid;
  assign bus.px_x      = r_px_x;
  assign bus.px_y      = r_px_y;
  assign bus.px_colour = r_px_colour;
  assign bus.cur_x     = r_cur_x;
  assign bus.cur_y     = r_cur_y;
  assign bus.busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: doc/px_cmd_ctrl.md
Name: px_cmd_ctrl

Overview:
- Front-panel command sequencer between the input synchroniser and the display driver.
- Consumes the already-synchronised buttons[3:1], switches[1:0] and px_ready.
- Debounces the buttons, turns them into step-cursor, plot and clear-screen commands, and issues pixel writes over a four-phase valid/ready handshake.
- Owns the cursor position and serialises all traffic to the display driver.

Parameters:
- XW, 4, cursor X width in bits; X range 0..2**XW-1.
- YW, 4, cursor Y width in bits; Y range 0..2**YW-1.
- DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a button change; minimum 2. Board builds override this to ~1,000,000.

Ports:
- clk  in  1  system clock.
- rst_a  in  1  reset; asynchronous, active-high.
- buttons  in  3 [3:1]  synchronised buttons. [1] = step cursor, [2] = plot, [3] = clear screen.
- switches  in  2 [1:0]  synchronised colour select.
- px_ready  in  1  synchronised ack from the display driver.
- px_valid  out  1  pixel write request.
- px_x  out  XW  write X coordinate.
- px_y  out  YW  write Y coordinate.
- px_colour  out  2  write colour.
- cur_x  out  XW  current cursor X.
- cur_y  out  YW  current cursor Y.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset: all outputs 0; cursor (0,0); FSM in IDLE; debounced button state 0; debounce counters 0.
- Reset is asynchronous and aborts any transfer or clear in progress; px_valid drops immediately.
- Debounce, per button:
  - Counter clears whenever the raw input equals the stable value; otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while the input still differs, the stable value takes the input and the counter clears.
  - A 0->1 change of the stable value gives a one-cycle registered press pulse on the following cycle. Releases produce no pulse.
  - Example: input high from cycle 0 -> stable=1 at cycle DEBOUNCE_CYCLES-1 -> pulse at cycle DEBOUNCE_CYCLES.
- FSM states: IDLE, REQ, RELEASE, CLR_REQ, CLR_RELEASE.
- IDLE:
  - Press pulses are acted on only when px_ready=0; pulses arriving otherwise are dropped, not queued.
  - Priority when pulses coincide: clear > plot > step; lower-priority pulses that cycle are dropped.
  - Step: cur_x+1. At cur_x=2**XW-1, cur_x wraps to 0 and cur_y+1. At cur_y=2**YW-1 with X wrapping, cursor wraps to (0,0). Step takes effect the next cycle and causes no bus activity.
  - Plot: latch px_x=cur_x, px_y=cur_y, px_colour=switches; assert px_valid the next cycle; go to REQ.
  - Clear: load px_x=0, px_y=0, px_colour=0; assert px_valid; go to CLR_REQ.
- REQ: hold px_valid=1 and px_x/px_y/px_colour stable. On px_ready=1, deassert px_valid next cycle and go to RELEASE.
- RELEASE: wait for px_ready=0, then go to IDLE.
- CLR_REQ / CLR_RELEASE:
  - Same handshake as REQ / RELEASE.
  - On px_ready=0 in CLR_RELEASE, advance px_x/px_y in raster order: X fastest, wrapping into Y.
  - If the pixel just written was (2**XW-1, 2**YW-1), go to IDLE. Otherwise reassert px_valid next cycle and return to CLR_REQ.
- The cursor is not changed by clear or plot.
- Button presses during any non-IDLE state are dropped; busy=1 throughout.
- switches are sampled only at the plot-accept cycle; later changes do not affect an in-flight write.
- No timeout: a driver that never raises px_ready holds the FSM in REQ indefinitely.
- Minimum of 3 cycles per pixel write. A full clear issues exactly 2**(XW+YW) handshakes.

Test Plan:
- Reset: assert rst_a mid-clear at pixel (5,2) -> px_valid=0, busy=0, cursor (0,0) immediately; no further requests after release.
- Debounce, DEBOUNCE_CYCLES=4:
  - 2-cycle glitch on buttons[1] -> cursor unchanged.
  - 6-cycle press -> exactly one step, cursor (1,0).
- Wrap: with cursor (15,15), XW=YW=4, one step -> (0,0); with cursor (15,3), one step -> (0,4).
- Plot: cursor (3,7), switches=2'b10, press buttons[2].
  - px_valid=1 with px_x=3, px_y=7, px_colour=2.
  - Driver raises px_ready after 5 cycles -> px_valid=0 the next cycle.
  - busy=1 until px_ready returns to 0.
- Clear: press buttons[3].
  - Exactly 256 handshakes, coordinates (0,0)..(15,15) in raster order, colour 0.
  - A step press during the clear is ignored (cursor unchanged); busy falls after the last ack is released.
- Priority and stale ack:
  - buttons[2] and buttons[3] debounced in the same cycle -> clear runs, no plot.
  - Plot press while px_ready is held high in IDLE -> dropped; px_valid stays 0.
